// File: rtl/mesh_audio_fifo.sv
// mesh_audio_fifo: buffers 2.16 mesh samples and streams them to the codec as saturated 16-bit PCM
//   clk, reset (async, active-low)
//   sample_in/sample_strobe : mesh sample, captured on strobe 0->1
//   flush                   : empties FIFO, back to priming
//   audio_req               : codec request pulse
//   audio_out/audio_valid   : PCM sample, valid one cycle after request
//   level                   : FIFO occupancy
//   overflow/underflow      : sticky error flags
//   streaming               : high while streaming
//   MESH_FIFO_STATS_EN adds saturating ovf_count/unf_count
module mesh_audio_fifo #(
    parameter int DEPTH = 16,
    parameter int PRIME = 8,
    parameter int SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [17:0]                sample_in,
    input  logic                       sample_strobe,
    input  logic                       flush,
    input  logic                       audio_req,
    output logic [15:0]                audio_out,
    output logic                       audio_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
`ifdef MESH_FIFO_STATS_EN
    output logic [15:0]                ovf_count,
    output logic [15:0]                unf_count,
`endif
    output logic                       streaming
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic {S_PRIME, S_STREAM} state_t;
    state_t state, state_d;
    logic strobe_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [17:0] mem [DEPTH];
    logic wr_ev, full, rd_en, unf_ev, wr_ok, ovf_ev;
    logic signed [17:0] shifted;
    logic [15:0] pcm;

    // flush discards any strobe edge and request in its cycle
    assign wr_ev     = sample_strobe & ~strobe_d & ~flush;
    assign full      = level == LW'(DEPTH);
    assign streaming = state == S_STREAM;
    assign rd_en     = streaming & audio_req & (level != '0) & ~flush;
    assign unf_ev    = streaming & audio_req & (level == '0) & ~flush;
    // a same-cycle read frees the slot a full FIFO needs
    assign wr_ok     = wr_ev & (~full | rd_en);
    assign ovf_ev    = wr_ev & ~wr_ok;
    assign shifted   = $signed(mem[rd_ptr]) >>> SHIFT;
    assign pcm       = (shifted > 18'sd32767) ? 16'h7FFF :
                       (shifted < -18'sd32768) ? 16'h8000 : shifted[15:0];

    always_comb begin
        state_d = flush ? S_PRIME :
                  (state == S_PRIME) ? ((level >= LW'(PRIME)) ? S_STREAM : S_PRIME) :
                  (unf_ev ? S_PRIME : S_STREAM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_PRIME;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_d    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            strobe_d    <= sample_strobe;
            audio_valid <= audio_req;
            overflow    <= overflow | ovf_ev;
            underflow   <= underflow | unf_ev;
            if (rd_en) audio_out <= pcm;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(wr_ok);
                rd_ptr <= rd_ptr + AW'(rd_en);
                level  <= level + LW'(wr_ok) - LW'(rd_en);
            end
        end
    end

`ifdef MESH_FIFO_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            ovf_count <= ovf_count + ((ovf_ev && ovf_count != 16'hFFFF) ? 16'd1 : 16'd0);
            unf_count <= unf_count + ((unf_ev && unf_count != 16'hFFFF) ? 16'd1 : 16'd0);
        end
    end
`endif
endmodule

// File: tb/tb_mesh_audio_fifo.sv
// tb_mesh_audio_fifo: directed vector bench for mesh_audio_fifo
module tb_mesh_audio_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [17:0] sample_in = '0;
    logic        sample_strobe = 1'b0;
    logic        flush = 1'b0;
    logic        audio_req = 1'b0;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic [4:0]  level;
    logic        overflow, underflow, streaming;
`ifdef MESH_FIFO_STATS_EN
    logic [15:0] ovf_count, unf_count;
`endif
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        stb;
        logic [17:0] smp;
        logic        req;
        logic [4:0]  lvl;
        logic        str;
        logic        vld;
        logic [15:0] out;
        logic        uf;
    } vec_t;
    vec_t v[$];

    mesh_audio_fifo #(.DEPTH(16), .PRIME(8), .SHIFT(2)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_strobe(sample_strobe),
        .flush(flush), .audio_req(audio_req), .audio_out(audio_out), .audio_valid(audio_valid),
        .level(level), .overflow(overflow), .underflow(underflow),
`ifdef MESH_FIFO_STATS_EN
        .ovf_count(ovf_count), .unf_count(unf_count),
`endif
        .streaming(streaming)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic stb, logic [17:0] smp, logic req, logic [4:0] lvl,
                                logic str, logic vld, logic [15:0] out, logic uf);
        vec_t r;
        r.stb = stb; r.smp = smp; r.req = req; r.lvl = lvl;
        r.str = str; r.vld = vld; r.out = out; r.uf = uf;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic stb, input logic [17:0] smp, input logic fl, input logic req);
        sample_strobe = stb;
        sample_in     = smp;
        flush         = fl;
        audio_req     = req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 1; k <= 8; k++) begin
            v.push_back(mk(1, 18'h0_4000, 0, 5'(k), 0, 0, 16'h0000, 0));
            v.push_back(mk(0, 18'h0_4000, 0, 5'(k), k == 8, 0, 16'h0000, 0));
        end
        v.push_back(mk(0, 18'h0, 1, 7, 1, 1, 16'h1000, 0));
        v.push_back(mk(0, 18'h0, 0, 7, 1, 0, 16'h1000, 0));
        v.push_back(mk(1, 18'h1_FFFF, 0, 8, 1, 0, 16'h1000, 0));
        v.push_back(mk(0, 18'h0, 0, 8, 1, 0, 16'h1000, 0));
        v.push_back(mk(1, 18'h2_0000, 0, 9, 1, 0, 16'h1000, 0));
        v.push_back(mk(0, 18'h0, 0, 9, 1, 0, 16'h1000, 0));
        for (int i = 0; i < 7; i++)
            v.push_back(mk(0, 18'h0, 1, 5'(8 - i), 1, 1, 16'h1000, 0));
        v.push_back(mk(0, 18'h0, 1, 1, 1, 1, 16'h7FFF, 0));
        v.push_back(mk(0, 18'h0, 1, 0, 1, 1, 16'h8000, 0));
        v.push_back(mk(0, 18'h0, 0, 0, 1, 0, 16'h8000, 0));
        v.push_back(mk(0, 18'h0, 1, 0, 0, 1, 16'h8000, 1));
        v.push_back(mk(0, 18'h0, 0, 0, 0, 0, 16'h8000, 1));

        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_out", 32'(audio_out), 0);
        check("rst_valid", 32'(audio_valid), 0);
        check("rst_streaming", 32'(streaming), 0);
        check("rst_flags", {30'b0, overflow, underflow}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (v[i]) begin
            step(v[i].stb, v[i].smp, 1'b0, v[i].req);
            check($sformatf("vec%0d_level", i), 32'(level), 32'(v[i].lvl));
            check($sformatf("vec%0d_streaming", i), 32'(streaming), 32'(v[i].str));
            check($sformatf("vec%0d_valid", i), 32'(audio_valid), 32'(v[i].vld));
            check($sformatf("vec%0d_out", i), 32'(audio_out), 32'(v[i].out));
            check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(v[i].uf));
        end
`ifdef MESH_FIFO_STATS_EN
        check("unf_count", 32'(unf_count), 1);
`endif

        // strobe held high captures a single sample
        repeat (10) step(1, 18'h0_8000, 0, 0);
        step(0, 18'h0, 0, 0);
        check("hold_level", 32'(level), 1);
        check("hold_streaming", 32'(streaming), 0);
        step(0, 18'h0, 0, 1);
        check("prime_req_valid", 32'(audio_valid), 1);
        check("prime_req_out", 32'(audio_out), 16'h8000);
        check("prime_req_level", 32'(level), 1);
        step(0, 18'h0, 0, 0);

        // fill to full, then one more edge overflows
        repeat (15) begin
            step(1, 18'h0_8000, 0, 0);
            step(0, 18'h0, 0, 0);
        end
        check("full_level", 32'(level), 16);
        check("full_ovf_clear", 32'(overflow), 0);
        check("full_streaming", 32'(streaming), 1);
        step(1, 18'h0_8000, 0, 0);
        step(0, 18'h0, 0, 0);
        check("ovf_level", 32'(level), 16);
        check("ovf_flag", 32'(overflow), 1);
`ifdef MESH_FIFO_STATS_EN
        check("ovf_count", 32'(ovf_count), 1);
`endif

        // drain to 5, then flush alongside a strobe edge
        repeat (11) step(0, 18'h0, 0, 1);
        step(0, 18'h0, 0, 0);
        check("drain_level", 32'(level), 5);
        check("drain_out", 32'(audio_out), 16'h2000);
        step(1, 18'h0_4000, 1, 0);
        check("flush_level", 32'(level), 0);
        check("flush_streaming", 32'(streaming), 0);
        check("flush_out", 32'(audio_out), 16'h2000);
        step(0, 18'h0, 0, 0);
        check("flush_level2", 32'(level), 0);
        check("flush_sticky", {30'b0, overflow, underflow}, 3);

        // refill, stream one sample, then async reset mid-stream
        repeat (8) begin
            step(1, 18'h0_4000, 0, 0);
            step(0, 18'h0, 0, 0);
        end
        check("refill_streaming", 32'(streaming), 1);
        step(0, 18'h0, 0, 1);
        check("refill_out", 32'(audio_out), 16'h1000);
        check("refill_valid", 32'(audio_valid), 1);
        #3;
        reset = 1'b0;
        #1;
        check("async_out", 32'(audio_out), 0);
        check("async_valid", 32'(audio_valid), 0);
        check("async_level", 32'(level), 0);
        check("async_streaming", 32'(streaming), 0);
        check("async_flags", {30'b0, overflow, underflow}, 0);
`ifdef MESH_FIFO_STATS_EN
        check("async_counts", {ovf_count, unf_count}, 0);
`endif
        audio_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(0, 18'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mesh_audio_fifo.md
Name: mesh_audio_fifo

Overview:
- Sits directly downstream of compMesh.
- Captures one 18-bit 2.16 signed mesh sample on each rising edge of the mesh's allValid strobe.
- Buffers samples in a small FIFO and delivers them to the audio codec interface, one per codec request, converted to saturated 16-bit signed PCM.
- Decouples the mesh's variable per-sample compute time from the fixed audio sample rate.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- PRIME, 8, occupancy required before streaming starts; 1..DEPTH.
- SHIFT, 2, right-shift applied to the 18-bit sample before 16-bit saturation; 0..4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- sample_in  in  18  mesh output, 2.16 two's complement
- sample_strobe  in  1  mesh allValid; a sample is taken on its 0->1 transition only
- flush  in  1  synchronous; empties FIFO and returns to PRIME, used on drum re-strike
- audio_req  in  1  one-cycle pulse from codec interface requesting the next sample
- audio_out  out  16  signed PCM sample
- audio_valid  out  1  one-cycle pulse, audio_out updated this cycle
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- underflow  out  1  sticky; a request arrived while streaming with the FIFO empty
- streaming  out  1  high in STREAM state

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and level go to 0; state goes to PRIME.
  - audio_out=0, audio_valid=0, overflow=0, underflow=0, streaming=0.
  - Edge-detect register is cleared to 0. A strobe already high at reset release therefore counts as a rising edge on the first clock.
- Capture:
  - Register sample_strobe; write when strobe & ~strobe_d.
  - sample_in is taken in the same cycle as that write.
  - Write when full: the sample is dropped, overflow is set, and the FIFO is unchanged.
- Conversion, applied at read time:
  - s = sample_in >>> SHIFT (arithmetic).
  - If s > 32767, output 32767; if s < -32768, output -32768; otherwise output s[15:0].
  - With SHIFT=2, 18'h0_4000 (0.25) maps to 16'h1000, and 18'h1_FFFF saturates to 16'h7FFF.
- States:
  - PRIME:
    - audio_req returns audio_out unchanged (0 after reset) with audio_valid=1, and nothing is read.
    - Go to STREAM when level >= PRIME.
  - STREAM:
    - audio_req with level>0: pop the head, and audio_out takes the converted value on the next clock edge. audio_valid pulses in the cycle after audio_req (latency 1).
    - audio_req with level==0: audio_out holds its last value, audio_valid pulses, underflow is set, and state returns to PRIME.
- Simultaneous events:
  - Write and read in the same cycle with the FIFO full: the read frees a slot, so the write succeeds and level is unchanged.
  - Write and read in the same cycle with the FIFO empty in STREAM: counts as underflow; the write is accepted and level becomes 1.
- flush:
  - Clears pointers and level, and forces PRIME in the next cycle.
  - audio_out is retained. Sticky flags are retained; only reset clears them.
  - Flush has priority over a write or read in the same cycle; any strobe edge in that cycle is discarded.
- Pointers wrap modulo DEPTH. Level is never greater than DEPTH and never negative.

Optional Feature:
- Macro MESH_FIFO_STATS_EN.
- When defined:
  - Adds outputs ovf_count[15:0] and unf_count[15:0], which count every dropped write and every underflow request.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- When undefined: these ports and counters do not exist, and the sticky flags alone report errors.

Test Plan:
- Reset release, then 8 strobe edges with sample_in=18'h0_4000 and no requests -> level=8, streaming=1 after the 8th write. The next audio_req gives audio_out=16'h1000 with audio_valid one cycle later, and level=7.
- Strobe held high for 10 cycles -> exactly one write (level=1), confirming edge-only capture.
- 17 strobe edges with DEPTH=16 and no requests -> level=16 and overflow=1. With stats enabled, ovf_count=1.
- In STREAM, drain to level 0, then issue audio_req -> audio_out holds its last value, audio_valid=1, underflow=1, streaming=0.
- Saturation: samples 18'h1_FFFF and 18'h2_0000 (negative full scale) read out as 16'h7FFF and 16'h8000.
- flush at level=5 together with a strobe edge -> level=0 the next cycle, state PRIME, audio_out unchanged. Asserting reset=0 mid-stream clears all outputs asynchronously, without waiting for a clk edge.
